chan_mux_seq: RTL and testbench

Parametrised, registered N-channel word selector; next generation of the team's 4:1 byte mux tree. Supports single-channel select, two-channel pair concatenation (2W-bit result), and an automatic scan mode that streams every enabled channel in ascending order. Output uses a valid/ready handshake so downstream logic can stall it. Sits between channel sample registers and downstream packing/display logic.

---
 rtl/chan_mux_seq_if.sv | 30 +++
 rtl/chan_mux_seq.sv | 120 ++++++++++++
 tb/tb_chan_mux_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/chan_mux_seq_if.sv
// Channel-select request/result bundle between sample registers and the
// selector. slave = selector side, master = driver/consumer side.
interface chan_mux_seq_if #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int SELW = 3
);
    logic [N*W-1:0]  din;
    logic [1:0]      mode;
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic [N-1:0]    chan_en;
    logic            start;
    logic            out_ready;
    logic            out_valid;
    logic [2*W-1:0]  dout;
    logic [SELW-1:0] out_chan;
    logic            busy;
    logic            done;

    modport slave (
        input  din, mode, sel_a, sel_b, chan_en, start, out_ready,
        output out_valid, dout, out_chan, busy, done
    );

    modport master (
        output din, mode, sel_a, sel_b, chan_en, start, out_ready,
        input  out_valid, dout, out_chan, busy, done
    );
endinterface

// File: rtl/chan_mux_seq.sv
// Registered N-channel word selector: direct pick, pair concatenation, or an
// ascending scan over enabled channels, with a valid/ready output stage.
module chan_mux_seq #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int SELW = 3
) (
    input  logic           clk,
    input  logic           rst,
    chan_mux_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t          r_state, w_state_nxt;
    logic            r_scan, w_scan_nxt;
    logic [N-1:0]    r_en, w_en_nxt;
    logic [SELW-1:0] r_idx, w_idx_nxt;
    logic            r_valid, w_valid_nxt;
    logic [2*W-1:0]  r_dout, w_dout_nxt;
    logic [SELW-1:0] r_chan, w_chan_nxt;
    logic            r_done, w_done_nxt;

    logic [W-1:0]    w_ch [N];

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign w_ch[k] = bus.din[k*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_scan  <= 1'b0;
            r_en    <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_chan  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scan  <= w_scan_nxt;
            r_en    <= w_en_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_dout  <= w_dout_nxt;
            r_chan  <= w_chan_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scan_nxt  = r_scan;
        w_en_nxt    = r_en;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_dout_nxt  = r_dout;
        w_chan_nxt  = r_chan;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_en_nxt   = bus.chan_en;
                    w_scan_nxt = (bus.mode == 2'b01);
                    if (bus.mode == 2'b01) begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = '0;
                    end else begin
                        // Direct/pair load on the same edge the request is taken
                        w_state_nxt = S_HOLD;
                        w_valid_nxt = 1'b1;
                        if (bus.mode == 2'b10) begin
                            w_dout_nxt = {w_ch[bus.sel_a], w_ch[bus.sel_b]};
                            w_chan_nxt = bus.sel_b;
                        end else begin
                            w_dout_nxt = {{W{1'b0}}, w_ch[bus.sel_a]};
                            w_chan_nxt = bus.sel_a;
                        end
                    end
                end
            end
            S_SCAN: begin
                if (r_en[r_idx]) begin
                    w_state_nxt = S_HOLD;
                    w_valid_nxt = 1'b1;
                    w_dout_nxt  = {{W{1'b0}}, w_ch[r_idx]};
                    w_chan_nxt  = r_idx;
                end else if (r_idx == LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_valid && bus.out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (!r_scan || r_idx == LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Scan resumes at the next index; idx never wraps
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.out_valid = r_valid;
    assign bus.dout      = r_dout;
    assign bus.out_chan  = r_chan;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
endmodule

// File: tb/tb_chan_mux_seq.sv
// Randomized check of chan_mux_seq against a transaction-level model:
// expected word list per operation plus arithmetic timing of words and done.
module tb_chan_mux_seq;
    localparam int W = 8, N = 8, SELW = 3;
    localparam logic [63:0] PLAN_DATA = 64'hD2C7B8A5_D2C7B8A5;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] d;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chan_mux_seq_if #(.W(W), .N(N), .SELW(SELW)) bus ();
    chan_mux_seq #(.W(W), .N(N), .SELW(SELW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_cfg();
        bus.mode    = 2'($urandom_range(0, 3));
        bus.sel_a   = 3'($urandom_range(0, 7));
        bus.sel_b   = 3'($urandom_range(0, 7));
        bus.chan_en = 8'($urandom);
    endtask

    // stall: 0 = ready always high, 1 = random ready, 2 = ready low for 4 valid cycles per word
    task automatic run_op(input logic [1:0] m, input logic [2:0] sa, input logic [2:0] sb,
                          input logic [7:0] en, input int stall, input logic [63:0] data);
        word_t q[$];
        int    h_last = 0, k_last = -1, stall_cnt = 0, pulse_cyc, cyc;
        bit    prev_v = 1'b0, got_done = 1'b0;
        logic  scan;
        scan = (m == 2'b01);

        if (scan) begin
            for (int k = 0; k < N; k++)
                if (en[k]) q.push_back('{ch: 3'(k), d: {8'h00, data[k*8 +: 8]}});
        end else if (m == 2'b10) begin
            q.push_back('{ch: sb, d: {data[int'(sa)*8 +: 8], data[int'(sb)*8 +: 8]}});
        end else begin
            q.push_back('{ch: sa, d: {8'h00, data[int'(sa)*8 +: 8]}});
        end

        bus.din = data; bus.mode = m; bus.sel_a = sa; bus.sel_b = sb; bus.chan_en = en;
        bus.start = 1'b1;
        bus.out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        pulse_cyc = $urandom_range(1, 6);

        for (cyc = 1; cyc <= 300 && !got_done; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                got_done = 1'b1;
                chk("done_cyc", cyc, scan ? h_last + N - k_last : h_last + 1);
                chk("done_valid", bus.out_valid, 0);
                chk("done_busy", bus.busy, 0);
                chk("words_left", q.size(), 0);
            end else begin
                chk("busy", bus.busy, 1);
                if (bus.out_valid) begin
                    if (q.size() == 0) chk("extra_word", bus.out_valid, 0);
                    else begin
                        if (!prev_v)
                            chk("appear_cyc", cyc, scan ? h_last + int'(q[0].ch) - k_last + 1 : 1);
                        chk("dout", bus.dout, q[0].d);
                        chk("out_chan", bus.out_chan, q[0].ch);
                    end
                end
            end
            prev_v = bus.out_valid;

            // next-cycle drives; a start pulse while busy must be ignored
            bus.start = (cyc == pulse_cyc && bus.busy && !bus.done);
            scramble_cfg();
            if (!scan) bus.din = {$urandom, $urandom};
            if (bus.out_valid) stall_cnt++;
            case (stall)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (stall_cnt >= 4);
            endcase
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                h_last = cyc;
                k_last = int'(q[0].ch);
                void'(q.pop_front());
                stall_cnt = 0;
            end
        end
        if (!got_done) chk("done_timeout", got_done, 1);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_valid", bus.out_valid, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_busy", bus.busy, 0);
        end
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
    endtask

    initial begin
        bit ok;
        int seen_done;

        rst = 1'b1;
        bus.din = PLAN_DATA; bus.mode = 2'b00; bus.sel_a = '0; bus.sel_b = '0;
        bus.chan_en = '0; bus.start = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_chan", bus.out_chan, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 3'd2, 3'd0, 8'h00, 0, PLAN_DATA);
        run_op(2'b10, 3'd0, 3'd3, 8'h00, 2, PLAN_DATA);
        run_op(2'b01, 3'd0, 3'd0, 8'b1000_0101, 0, PLAN_DATA);
        run_op(2'b01, 3'd0, 3'd0, 8'h00, 0, PLAN_DATA);
        run_op(2'b11, 3'd1, 3'd6, 8'h00, 1, PLAN_DATA);
        run_op(2'b10, 3'd5, 3'd5, 8'h00, 1, PLAN_DATA);
        run_op(2'b01, 3'd0, 3'd0, 8'hFF, 2, PLAN_DATA);

        // Abort: rst while the second scan word is pending
        bus.din = PLAN_DATA; bus.mode = 2'b01; bus.chan_en = 8'hFF;
        bus.start = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(20, ok);
        chk("abort_word1", ok, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        wait_valid(20, ok);
        chk("abort_word2", ok, 1);
        chk("abort_chan2", bus.out_chan, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_dout", bus.dout, 0);
        chk("abort_chan", bus.out_chan, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done_now", bus.done, 0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.out_valid) seen_done++;
        end
        chk("abort_quiet", seen_done, 0);

        // rst and start together: rst wins
        bus.mode = 2'b00; bus.start = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        @(negedge clk);
        chk("rst_start_valid", bus.out_valid, 0);

        for (int r = 0; r < 40; r++) begin
            logic [7:0] en;
            en = 8'($urandom);
            if (r % 10 == 3) en = 8'h00;
            if (r % 10 == 7) en = 8'hFF;
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   en, $urandom_range(0, 2), {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
